// File: rtl/clock_set_controller.sv
// Control sequencer for the 28-bit seconds counter: 1 Hz tick, set-mode step pulses,
// field select and epoch load strobe. mode is the FSM state itself (RUN/SET/LOAD).
module clock_set_controller #(
  parameter int CLK_HZ        = 100000000,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_next,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        unix_valid,
  input  logic [27:0] unix_in,
  output logic        enable,
  output logic        increment,
  output logic        decrement,
  output logic [2:0]  mode,
  output logic [3:0]  selected,
  output logic [27:0] t_unix,
  output logic        unix_load
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [HW-1:0] HOLD_FULL  = HW'(HOLD_CYCLES);
  localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_RUN  = 3'b000,
    ST_SET  = 3'b001,
    ST_LOAD = 3'b010
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   presc_q;
  logic [HW-1:0]   hold_q, hold_d;
  logic [RW-1:0]   rep_q, rep_d;
  logic [3:0]      sync1_q, sync2_q, sync3_q;   // bit order {down, up, next, mode}
  logic [3:0]      selected_q;
  logic [27:0]     t_unix_q;
  logic            enable_q, increment_q, decrement_q, unix_load_q;

  logic [3:0]      btn_press;
  logic            up_held, dn_held, one_held, in_set, rep_hit, step;

  // Auto-repeat: hold_q saturates at HOLD_CYCLES, after which rep_q paces the repeats.
  always_comb begin
    btn_press = sync2_q & ~sync3_q;
    up_held   = sync2_q[2];
    dn_held   = sync2_q[3];
    one_held  = up_held ^ dn_held;
    in_set    = (state_q == ST_SET) && !btn_press[0];
    hold_d    = '0;
    rep_d     = '0;
    rep_hit   = 1'b0;
    if (in_set && one_held) begin
      if (btn_press[2] || btn_press[3]) begin
        hold_d = HW'(1);
      end else if (hold_q != HOLD_FULL) begin
        hold_d = hold_q + HW'(1);
      end else begin
        hold_d  = hold_q;
        rep_hit = (rep_q == '0);
        rep_d   = (rep_q == REP_LAST) ? '0 : rep_q + RW'(1);
      end
    end
    step = in_set && one_held && (btn_press[2] || btn_press[3] || rep_hit);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      presc_q     <= '0;
      hold_q      <= '0;
      rep_q       <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync3_q     <= '0;
      selected_q  <= 4'b0001;
      t_unix_q    <= '0;
      enable_q    <= 1'b0;
      increment_q <= 1'b0;
      decrement_q <= 1'b0;
      unix_load_q <= 1'b0;
    end else begin
      sync1_q     <= {btn_down, btn_up, btn_next, btn_mode};
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      hold_q      <= hold_d;
      rep_q       <= rep_d;
      enable_q    <= 1'b0;
      increment_q <= step & up_held;
      decrement_q <= step & dn_held;
      unix_load_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          // Epoch load outranks both the mode button and the pending tick.
          if (unix_valid) begin
            state_q     <= ST_LOAD;
            t_unix_q    <= unix_in;
            unix_load_q <= 1'b1;
            presc_q     <= '0;
          end else if (btn_press[0]) begin
            state_q <= ST_SET;
            presc_q <= '0;
          end else if (presc_q == PRESC_LAST) begin
            presc_q  <= '0;
            enable_q <= 1'b1;
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        ST_SET: begin
          if (btn_press[0]) begin
            state_q <= ST_RUN;
          end else if (btn_press[1]) begin
            selected_q <= {selected_q[2:0], selected_q[3]};
          end
        end
        ST_LOAD: begin
          state_q <= ST_RUN;
          presc_q <= '0;
        end
        default: begin
          state_q <= ST_RUN;
          presc_q <= '0;
        end
      endcase
    end
  end

  assign mode      = state_q;
  assign selected  = selected_q;
  assign t_unix    = t_unix_q;
  assign enable    = enable_q;
  assign increment = increment_q;
  assign decrement = decrement_q;
  assign unix_load = unix_load_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller: directed scenarios followed by random button/strobe
// traffic, every cycle compared against a cycle-level behavioural model.
module tb_clock_set_controller;

  localparam int CLK_HZ = 10;
  localparam int HOLD   = 20;
  localparam int REP    = 5;

  typedef logic [38:0] vec_t;   // {enable, increment, decrement, unix_load, mode, selected, t_unix}
  localparam vec_t RESET_VEC = {4'b0000, 3'b000, 4'b0001, 28'h0};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        btn_mode = 1'b0, btn_next = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic        unix_valid = 1'b0;
  logic [27:0] unix_in = '0;
  logic        enable, increment, decrement, unix_load;
  logic [2:0]  mode;
  logic [3:0]  selected;
  logic [27:0] t_unix;

  clock_set_controller #(.CLK_HZ(CLK_HZ), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut (
    .clk(clk), .reset(reset),
    .btn_mode(btn_mode), .btn_next(btn_next), .btn_up(btn_up), .btn_down(btn_down),
    .unix_valid(unix_valid), .unix_in(unix_in),
    .enable(enable), .increment(increment), .decrement(decrement),
    .mode(mode), .selected(selected), .t_unix(t_unix), .unix_load(unix_load)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int   checks = 0, passes = 0, fails = 0;
  vec_t exp_q[$];
  int   cyc = 0, en_cnt = 0, inc_cnt = 0, dec_cnt = 0;
  int   first_en = -1, last_en = -1, first_inc = -1, last_inc = -1, first_dec = -1;

  // ---------------- reference model ----------------
  int          m_mode;        // 0 RUN, 1 SET, 2 LOAD
  int          m_idx;         // selected field index 0..3
  logic [27:0] m_tunix;
  int          run_age;       // edges spent in RUN since entering it
  int          streak_len;    // consecutive SET cycles one direction has been seen held
  bit          streak_up;
  logic [3:0]  h1, h2, h3;    // raw buttons sampled 1, 2, 3 edges ago

  function automatic void model_reset();
    m_mode = 0; m_idx = 0; m_tunix = '0; run_age = 0;
    streak_len = 0; streak_up = 1'b0;
    h1 = '0; h2 = '0; h3 = '0;
  endfunction

  function automatic void model_step();
    logic [3:0] seen, press;
    bit e_en, e_inc, e_dec, e_load, up, pulse;
    int k;
    e_en = 0; e_inc = 0; e_dec = 0; e_load = 0;
    if (!reset) begin
      model_reset();
    end else begin
      seen  = h2;
      press = h2 & ~h3;
      case (m_mode)
        0: begin
          run_age++;
          streak_len = 0;
          if (unix_valid) begin
            m_mode = 2; m_tunix = unix_in; e_load = 1;
          end else if (press[0]) begin
            m_mode = 1;
          end else if (run_age % CLK_HZ == 0) begin
            e_en = 1;
          end
        end
        1: begin
          if (press[0]) begin
            m_mode = 0; run_age = 0; streak_len = 0;
          end else begin
            if (press[1]) m_idx = (m_idx + 1) % 4;
            if (seen[2] ^ seen[3]) begin
              up = seen[2];
              if (streak_len > 0 && streak_up == up) streak_len++;
              else begin streak_len = 1; streak_up = up; end
              k = streak_len - 1;
              pulse = (up ? press[2] : press[3]) || (k >= HOLD && (k - HOLD) % REP == 0);
              if (pulse && up) e_inc = 1;
              if (pulse && !up) e_dec = 1;
            end else begin
              streak_len = 0;
            end
          end
        end
        default: begin
          m_mode = 0; run_age = 0; streak_len = 0;
        end
      endcase
      h3 = h2; h2 = h1; h1 = {btn_down, btn_up, btn_next, btn_mode};
    end
    exp_q.push_back({e_en, e_inc, e_dec, e_load, 3'(m_mode), 4'b0001 << m_idx, m_tunix});
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic vec_t obs_vec();
    return {enable, increment, decrement, unix_load, mode, selected, t_unix};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      vec_t e;
      logic ok;
      @(posedge clk);
      model_step();
      #1;
      cyc++;
      e = exp_q.pop_front();
      check("cycle_outputs", obs_vec(), e);
      ok = ($countones({enable, increment, decrement, unix_load}) <= 1);
      check("one_trigger", ok, 1);
      if (enable)    begin en_cnt++;  last_en = cyc;  if (first_en < 0)  first_en = cyc;  end
      if (increment) begin inc_cnt++; last_inc = cyc; if (first_inc < 0) first_inc = cyc; end
      if (decrement) begin dec_cnt++; if (first_dec < 0) first_dec = cyc; end
    end
  endtask

  task automatic press_btn(input int idx);
    case (idx)
      0: btn_mode = 1'b1;
      1: btn_next = 1'b1;
      2: btn_up   = 1'b1;
      default: btn_down = 1'b1;
    endcase
    tick(2);
    btn_mode = 1'b0; btn_next = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    tick(3);
  endtask

  task automatic clear_counts();
    en_cnt = 0; inc_cnt = 0; dec_cnt = 0;
    first_en = -1; last_en = -1; first_inc = -1; last_inc = -1; first_dec = -1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0]  sel_tab [4];
    logic [27:0] last_loaded;
    int start, load_cyc, n;
    sel_tab = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    model_reset();

    // Reset state, then free-running tick
    tick(3);
    check("reset_state", obs_vec(), RESET_VEC);
    reset = 1'b1;
    clear_counts();
    start = cyc;
    tick(35);
    check("tick_count", en_cnt, 3);
    check("first_tick", first_en - start, 10);
    check("last_tick", last_en - start, 30);
    check("run_select", selected, 4'b0001);

    // SET navigation
    clear_counts();
    press_btn(0);
    check("enter_set", mode, 3'b001);
    for (int i = 0; i < 4; i++) begin
      press_btn(1);
      check("select_rotate", selected, sel_tab[i]);
    end
    check("no_tick_in_set", en_cnt, 0);

    // Single up, then single down
    clear_counts();
    start = cyc;
    btn_up = 1'b1; tick(2); btn_up = 1'b0; tick(4);
    check("inc_once", inc_cnt, 1);
    check("inc_latency", first_inc - start, 3);
    start = cyc;
    btn_down = 1'b1; tick(2); btn_down = 1'b0; tick(4);
    check("dec_once", dec_cnt, 1);
    check("dec_latency", first_dec - start, 3);
    check("inc_still_once", inc_cnt, 1);

    // Auto-repeat with up held 40 cycles
    clear_counts();
    btn_up = 1'b1; tick(40); btn_up = 1'b0; tick(30);
    check("repeat_count", inc_cnt, 5);
    check("repeat_span", last_inc - first_inc, 35);

    // Mode and up pressed together in SET: exit without increment
    clear_counts();
    btn_mode = 1'b1; btn_up = 1'b1; tick(2);
    btn_mode = 1'b0; btn_up = 1'b0; tick(4);
    check("mode_up_no_inc", inc_cnt, 0);
    check("mode_up_exit", mode, 3'b000);

    // Epoch load on the prescaler terminal cycle
    n = 0;
    while (run_age % CLK_HZ != CLK_HZ - 1 && n < 2 * CLK_HZ) begin tick(1); n++; end
    unix_in = 28'h5F5E100; unix_valid = 1'b1;
    tick(1);
    unix_valid = 1'b0;
    load_cyc = cyc;
    check("load_strobe", unix_load, 1);
    check("load_mode", mode, 3'b010);
    check("load_value", t_unix, 28'h5F5E100);
    check("load_no_tick", enable, 0);
    tick(1);
    check("load_done", {unix_load, mode}, 4'b0000);
    clear_counts();
    n = 0;
    while (en_cnt == 0 && n < 3 * CLK_HZ) begin tick(1); n++; end
    check("tick_after_load", last_en - load_cyc, 11);

    // unix_valid beats a mode press in RUN
    last_loaded = 28'($urandom);
    btn_mode = 1'b1; tick(2);
    unix_in = last_loaded; unix_valid = 1'b1; tick(1);
    unix_valid = 1'b0; btn_mode = 1'b0;
    check("valid_beats_mode", mode, 3'b010);
    tick(3);
    check("mode_press_dropped", mode, 3'b000);

    // Reset mid-SET with up held and an ignored strobe
    press_btn(0);
    btn_up = 1'b1; tick(4);
    unix_in = 28'($urandom); unix_valid = 1'b1; tick(1);
    unix_valid = 1'b0;
    check("strobe_ignored", t_unix, last_loaded);
    check("strobe_ignored_mode", mode, 3'b001);
    #2 reset = 1'b0;
    #1 check("async_reset", obs_vec(), RESET_VEC);
    tick(3);
    reset = 1'b1;
    clear_counts();
    tick(30);
    check("no_pulse_after_reset", inc_cnt, 0);
    btn_up = 1'b0;
    tick(4);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(0, 7)  == 0) btn_next = ~btn_next;
      if ($urandom_range(0, 14) == 0) btn_up   = ~btn_up;
      if ($urandom_range(0, 14) == 0) btn_down = ~btn_down;
      unix_valid = ($urandom_range(0, 39) == 0);
      unix_in    = 28'($urandom);
      tick(1);
    end
    btn_mode = 1'b0; btn_next = 1'b0; btn_up = 1'b0; btn_down = 1'b0; unix_valid = 1'b0;
    tick(5);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
